// File: rtl/relu_offset_fp_if.sv
// Purpose : lane bundle for the ReLU-with-offset stage (producer -> stage -> SFU).
// Latency : none, wires only; the one-cycle stage lives in relu_offset_fp.
// Backpres: none; src_valid beats are always accepted, dst_valid has no ready.
//
// Ports (per modport):
//   master : drives enable, src_valid, src_{sign,exp,man}_0..7, offset_*; receives dst_*.
//   slave  : the stage itself; receives src/offset/enable and drives dst_valid, dst_*_0..7.
// Floats are carried as separate sign / biased exponent / mantissa fields.

interface relu_offset_fp_if #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
);

  logic             enable;
  logic             src_valid;

  logic [MAN_W-1:0] src_man_0, src_man_1, src_man_2, src_man_3;
  logic [MAN_W-1:0] src_man_4, src_man_5, src_man_6, src_man_7;
  logic [EXP_W-1:0] src_exp_0, src_exp_1, src_exp_2, src_exp_3;
  logic [EXP_W-1:0] src_exp_4, src_exp_5, src_exp_6, src_exp_7;
  logic             src_sign_0, src_sign_1, src_sign_2, src_sign_3;
  logic             src_sign_4, src_sign_5, src_sign_6, src_sign_7;

  logic [MAN_W-1:0] offset_man;
  logic [EXP_W-1:0] offset_exp;
  logic             offset_sign;

  logic             dst_valid;

  logic [MAN_W-1:0] dst_man_0, dst_man_1, dst_man_2, dst_man_3;
  logic [MAN_W-1:0] dst_man_4, dst_man_5, dst_man_6, dst_man_7;
  logic [EXP_W-1:0] dst_exp_0, dst_exp_1, dst_exp_2, dst_exp_3;
  logic [EXP_W-1:0] dst_exp_4, dst_exp_5, dst_exp_6, dst_exp_7;
  logic             dst_sign_0, dst_sign_1, dst_sign_2, dst_sign_3;
  logic             dst_sign_4, dst_sign_5, dst_sign_6, dst_sign_7;

  modport master (
    output enable, src_valid,
    output src_man_0, src_man_1, src_man_2, src_man_3,
    output src_man_4, src_man_5, src_man_6, src_man_7,
    output src_exp_0, src_exp_1, src_exp_2, src_exp_3,
    output src_exp_4, src_exp_5, src_exp_6, src_exp_7,
    output src_sign_0, src_sign_1, src_sign_2, src_sign_3,
    output src_sign_4, src_sign_5, src_sign_6, src_sign_7,
    output offset_man, offset_exp, offset_sign,
    input  dst_valid,
    input  dst_man_0, dst_man_1, dst_man_2, dst_man_3,
    input  dst_man_4, dst_man_5, dst_man_6, dst_man_7,
    input  dst_exp_0, dst_exp_1, dst_exp_2, dst_exp_3,
    input  dst_exp_4, dst_exp_5, dst_exp_6, dst_exp_7,
    input  dst_sign_0, dst_sign_1, dst_sign_2, dst_sign_3,
    input  dst_sign_4, dst_sign_5, dst_sign_6, dst_sign_7
  );

  modport slave (
    input  enable, src_valid,
    input  src_man_0, src_man_1, src_man_2, src_man_3,
    input  src_man_4, src_man_5, src_man_6, src_man_7,
    input  src_exp_0, src_exp_1, src_exp_2, src_exp_3,
    input  src_exp_4, src_exp_5, src_exp_6, src_exp_7,
    input  src_sign_0, src_sign_1, src_sign_2, src_sign_3,
    input  src_sign_4, src_sign_5, src_sign_6, src_sign_7,
    input  offset_man, offset_exp, offset_sign,
    output dst_valid,
    output dst_man_0, dst_man_1, dst_man_2, dst_man_3,
    output dst_man_4, dst_man_5, dst_man_6, dst_man_7,
    output dst_exp_0, dst_exp_1, dst_exp_2, dst_exp_3,
    output dst_exp_4, dst_exp_5, dst_exp_6, dst_exp_7,
    output dst_sign_0, dst_sign_1, dst_sign_2, dst_sign_3,
    output dst_sign_4, dst_sign_5, dst_sign_6, dst_sign_7
  );

endinterface

// File: rtl/relu_offset_fp.sv
// Purpose : eight-lane fp32 dst = max(src, offset) with shared runtime offset; enable=0 bypasses.
// Latency : exactly 1 cycle; dst_valid is src_valid registered, dst data holds when src_valid=0.
// Backpres: none; every src_valid beat is accepted, downstream must always sink dst_valid.
//
// Ports: clk (rising edge), rstn (async active-low, clears dst_valid and all dst fields),
//        bus (relu_offset_fp_if.slave: enable, src_valid, src_*_0..7, offset_*, dst_*).
// Build option: define RELU_OFFSET_FTZ_EN to flush denormals to +0 for the compare and to
//        output +0 whenever a denormal src is selected (including bypass).
// LANES is fixed at 8 by the per-lane port names of the interface.

module relu_offset_fp #(
  parameter int LANES = 8,
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  relu_offset_fp_if.slave bus
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  fp_t  src_dat [LANES];
  fp_t  res_dat [LANES];
  fp_t  dst_dat [LANES];
  fp_t  off_dat;
  logic dst_vld;

  function automatic logic fp_is_nan(input fp_t f);
    return (&f.exp) && (|f.man);
  endfunction

  function automatic logic fp_is_zero(input fp_t f);
    return ~|{f.exp, f.man};
  endfunction

  function automatic logic fp_is_denorm(input fp_t f);
    return (~|f.exp) && (|f.man);
  endfunction

  // Strict a > b in sign-magnitude order; +0 and -0 are equal. Callers
  // filter NaNs first, so the {exp, man} magnitude order covers Inf too.
  function automatic logic fp_gt(input fp_t a, input fp_t b);
    logic r;
    if (fp_is_zero(a) && fp_is_zero(b))
      r = 1'b0;
    else if (a.sign != b.sign)
      r = ~a.sign;
    else if (!a.sign)
      r = {a.exp, a.man} > {b.exp, b.man};
    else
      r = {a.exp, a.man} < {b.exp, b.man};
    return r;
  endfunction

  // s_cmp doubles as the value emitted when src wins: with flushing it is
  // exactly +0 for a denormal src, otherwise it is src untouched. A losing
  // denormal offset still goes out with its original bits.
  function automatic fp_t relu_sel(input fp_t s, input fp_t o, input logic en);
    fp_t s_cmp;
    fp_t o_cmp;
    fp_t r;
`ifdef RELU_OFFSET_FTZ_EN
    s_cmp = fp_is_denorm(s) ? '0 : s;
    o_cmp = fp_is_denorm(o) ? '0 : o;
`else
    s_cmp = s;
    o_cmp = o;
`endif
    if (!en)
      r = s_cmp;
    else if (fp_is_nan(s))
      r = s;
    else if (fp_is_nan(o))
      r = o;
    else if (fp_gt(s_cmp, o_cmp))
      r = s_cmp;
    else
      r = o;
    return r;
  endfunction

  assign off_dat    = {bus.offset_sign, bus.offset_exp, bus.offset_man};

  assign src_dat[0] = {bus.src_sign_0, bus.src_exp_0, bus.src_man_0};
  assign src_dat[1] = {bus.src_sign_1, bus.src_exp_1, bus.src_man_1};
  assign src_dat[2] = {bus.src_sign_2, bus.src_exp_2, bus.src_man_2};
  assign src_dat[3] = {bus.src_sign_3, bus.src_exp_3, bus.src_man_3};
  assign src_dat[4] = {bus.src_sign_4, bus.src_exp_4, bus.src_man_4};
  assign src_dat[5] = {bus.src_sign_5, bus.src_exp_5, bus.src_man_5};
  assign src_dat[6] = {bus.src_sign_6, bus.src_exp_6, bus.src_man_6};
  assign src_dat[7] = {bus.src_sign_7, bus.src_exp_7, bus.src_man_7};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign res_dat[i] = relu_sel(src_dat[i], off_dat, bus.enable);
  end

  // Data only loads on accepted beats so the last result stays visible
  // through idle cycles; valid follows src_valid every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dst_vld <= 1'b0;
      for (int i = 0; i < LANES; i++) dst_dat[i] <= '0;
    end else begin
      dst_vld <= bus.src_valid;
      if (bus.src_valid) begin
        for (int i = 0; i < LANES; i++) dst_dat[i] <= res_dat[i];
      end
    end
  end

  assign bus.dst_valid = dst_vld;

  assign {bus.dst_sign_0, bus.dst_exp_0, bus.dst_man_0} = dst_dat[0];
  assign {bus.dst_sign_1, bus.dst_exp_1, bus.dst_man_1} = dst_dat[1];
  assign {bus.dst_sign_2, bus.dst_exp_2, bus.dst_man_2} = dst_dat[2];
  assign {bus.dst_sign_3, bus.dst_exp_3, bus.dst_man_3} = dst_dat[3];
  assign {bus.dst_sign_4, bus.dst_exp_4, bus.dst_man_4} = dst_dat[4];
  assign {bus.dst_sign_5, bus.dst_exp_5, bus.dst_man_5} = dst_dat[5];
  assign {bus.dst_sign_6, bus.dst_exp_6, bus.dst_man_6} = dst_dat[6];
  assign {bus.dst_sign_7, bus.dst_exp_7, bus.dst_man_7} = dst_dat[7];

endmodule

// File: tb/tb_relu_offset_fp.sv
// Purpose : directed self-checking bench for relu_offset_fp (fp32 values written as 32-bit hex).
// Latency : drives right after a rising edge, checks 1 time unit after the next rising edge.
// Backpres: none in the DUT; the bench just issues beats and idle cycles.

module tb_relu_offset_fp;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q [8];

`ifdef RELU_OFFSET_FTZ_EN
  localparam logic FTZ = 1'b1;
`else
  localparam logic FTZ = 1'b0;
`endif

  relu_offset_fp_if bus ();

  relu_offset_fp dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected value of a denormal src when it is the selected result.
  function automatic logic [31:0] dn(input logic [31:0] v);
    return FTZ ? 32'h0 : v;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] v);
    case (i)
      0: {bus.src_sign_0, bus.src_exp_0, bus.src_man_0} = v;
      1: {bus.src_sign_1, bus.src_exp_1, bus.src_man_1} = v;
      2: {bus.src_sign_2, bus.src_exp_2, bus.src_man_2} = v;
      3: {bus.src_sign_3, bus.src_exp_3, bus.src_man_3} = v;
      4: {bus.src_sign_4, bus.src_exp_4, bus.src_man_4} = v;
      5: {bus.src_sign_5, bus.src_exp_5, bus.src_man_5} = v;
      6: {bus.src_sign_6, bus.src_exp_6, bus.src_man_6} = v;
      7: {bus.src_sign_7, bus.src_exp_7, bus.src_man_7} = v;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] get_lane(input int i);
    logic [31:0] r;
    case (i)
      0: r = {bus.dst_sign_0, bus.dst_exp_0, bus.dst_man_0};
      1: r = {bus.dst_sign_1, bus.dst_exp_1, bus.dst_man_1};
      2: r = {bus.dst_sign_2, bus.dst_exp_2, bus.dst_man_2};
      3: r = {bus.dst_sign_3, bus.dst_exp_3, bus.dst_man_3};
      4: r = {bus.dst_sign_4, bus.dst_exp_4, bus.dst_man_4};
      5: r = {bus.dst_sign_5, bus.dst_exp_5, bus.dst_man_5};
      6: r = {bus.dst_sign_6, bus.dst_exp_6, bus.dst_man_6};
      7: r = {bus.dst_sign_7, bus.dst_exp_7, bus.dst_man_7};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic set_offset(input logic [31:0] v);
    {bus.offset_sign, bus.offset_exp, bus.offset_man} = v;
  endtask

  task automatic drive8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    set_lane(0, a0); set_lane(1, a1); set_lane(2, a2); set_lane(3, a3);
    set_lane(4, a4); set_lane(5, a5); set_lane(6, a6); set_lane(7, a7);
  endtask

  task automatic want8(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
    exp_q[4] = e4; exp_q[5] = e5; exp_q[6] = e6; exp_q[7] = e7;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_beat(input string tag, input logic exp_vld);
    check({tag, "/valid"}, {31'd0, bus.dst_valid}, {31'd0, exp_vld});
    for (int i = 0; i < 8; i++)
      check($sformatf("%s/lane%0d", tag, i), get_lane(i), exp_q[i]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with junk on the inputs.
    rstn          = 1'b0;
    bus.enable    = 1'b1;
    bus.src_valid = 1'b1;
    set_offset(32'h3F000000);
    drive8(32'hDEADBEEF, 32'h3F800000, 32'hC0000000, 32'h7FC00000,
           32'h12345678, 32'h40000000, 32'h00000001, 32'hFFFFFFFF);
    tick;
    want8(0, 0, 0, 0, 0, 0, 0, 0);
    check_beat("reset", 1'b0);

    // Plain ReLU, offset +0.
    rstn = 1'b1;
    set_offset(32'h00000000);
    drive8(32'h3F800000, 32'hC0000000, 32'h80000000, 32'h00000000,
           32'h00000001, 32'hFF800000, 32'h7F7FFFFF, 32'h80000001);
    tick;
    want8(32'h3F800000, 32'h0, 32'h0, 32'h0,
          dn(32'h00000001), 32'h0, 32'h7F7FFFFF, 32'h0);
    check_beat("relu", 1'b1);

    // Asynchronous reset in mid-cycle, no clock edge involved.
    #2;
    rstn = 1'b0;
    #1;
    want8(0, 0, 0, 0, 0, 0, 0, 0);
    check_beat("async_rst", 1'b0);
    bus.src_valid = 1'b0;
    rstn = 1'b1;
    tick;
    check_beat("post_rst_idle", 1'b0);

    // Offset +0.5, NaN src in lane 5.
    bus.src_valid = 1'b1;
    set_offset(32'h3F000000);
    drive8(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'hC0400000,
           32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h40000000);
    tick;
    want8(32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
          32'h7F800000, 32'h7FC00000, 32'h3F000000, 32'h40000000);
    check_beat("off_half", 1'b1);

    // Offset -0: equal zeros pick the offset bits.
    set_offset(32'h80000000);
    drive8(32'h00000000, 32'h3F800000, 32'h80000000, 32'hFF800000,
           32'h7F7FFFFF, 32'h00000001, 32'h80000001, 32'hBF800000);
    tick;
    want8(32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000,
          32'h7F7FFFFF, FTZ ? 32'h80000000 : 32'h00000001, 32'h80000000, 32'h80000000);
    check_beat("off_negzero", 1'b1);

    // NaN offset: src NaN still wins, everything else yields the offset NaN.
    set_offset(32'h7FC00001);
    drive8(32'h3F800000, 32'h7FA00000, 32'hFF800000, 32'h00000000,
           32'h7F800000, 32'hC0000000, 32'h3F000000, 32'h7FC00000);
    tick;
    want8(32'h7FC00001, 32'h7FA00000, 32'h7FC00001, 32'h7FC00001,
          32'h7FC00001, 32'h7FC00001, 32'h7FC00001, 32'h7FC00000);
    check_beat("off_nan", 1'b1);

    // Offset -1.0: negative-range ordering and denormal handling.
    set_offset(32'hBF800000);
    drive8(32'h00000001, 32'hBF000000, 32'hC0000000, 32'h80000001,
           32'hBF800000, 32'h3F800000, 32'hFF800000, 32'h7F800000);
    tick;
    want8(dn(32'h00000001), 32'hBF000000, 32'hBF800000, dn(32'h80000001),
          32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h7F800000);
    check_beat("off_neg1", 1'b1);

    // Bypass: src passes through, offset ignored.
    bus.enable = 1'b0;
    set_offset(32'h3F000000);
    drive8(32'hC0000000, 32'h7FC00000, 32'h00000001, 32'h80000000,
           32'hFF800000, 32'h3E800000, 32'h80000001, 32'h12345678);
    tick;
    want8(32'hC0000000, 32'h7FC00000, dn(32'h00000001), 32'h80000000,
          32'hFF800000, 32'h3E800000, dn(32'h80000001), 32'h12345678);
    check_beat("bypass", 1'b1);

    // Streaming 1,1,0,1 with offset +0 and positive data (passes unchanged).
    bus.enable = 1'b1;
    set_offset(32'h00000000);
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 32'h3F800000 + 32'(i) * 32'h00100000;
      set_lane(i, exp_q[i]);
    end
    tick;
    check_beat("stream_a", 1'b1);

    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 32'h40000000 + 32'(i) * 32'h00100000;
      set_lane(i, exp_q[i]);
    end
    tick;
    check_beat("stream_b", 1'b1);

    // Gap: negative junk on the lanes must not be captured.
    bus.src_valid = 1'b0;
    for (int i = 0; i < 8; i++) set_lane(i, 32'hC0000000);
    tick;
    check_beat("stream_gap", 1'b0);

    bus.src_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = 32'h41000000 + 32'(i) * 32'h00100000;
      set_lane(i, exp_q[i]);
    end
    tick;
    check_beat("stream_c", 1'b1);

    bus.src_valid = 1'b0;
    tick;
    check_beat("stream_idle", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
